jtag_cmd_master: RTL



---
 rtl/jtag_cmd_master.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/jtag_cmd_master.sv
// jtag_cmd_master: decodes host command bytes into single 32-bit bus transactions and returns status/read data
module jtag_cmd_master #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [7:0]  STATUS_OK      = 8'hA5,
   parameter logic [7:0]  STATUS_TIMEOUT = 8'hEE,
   parameter logic [7:0]  STATUS_BADCMD  = 8'hEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fifo_dataavailable,
   input  logic [7:0]  fifo_readdata,
   output logic        fifo_read,
   input  logic        fifo_readyfordata,
   output logic [7:0]  fifo_writedata,
   output logic        fifo_write,
   output logic        bus_cyc,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack
);
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_BUS, S_RESP} state_e;
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [15:0] tmo_q, tmo_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  status_q, status_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic        cyc_q, cyc_d;
   logic        wr_q, wr_d;
   logic [7:0]  wrd_q, wrd_d;
   logic [1:0]  bsel;
   logic [7:0]  resp_byte;
   logic        last;
   assign fifo_read = !rst && fifo_dataavailable && (state_q inside {S_IDLE, S_ADDR, S_WDATA});
   assign fifo_write = wr_q;
   assign fifo_writedata = wrd_q;
   assign bus_cyc = cyc_q;
   assign bus_we = we_q;
   assign bus_addr = addr_q;
   assign bus_wdata = wdata_q;
   // response byte 0 is the status, bytes 1..4 are read data LSB first
   assign bsel = 2'(idx_q - 3'd1);
   assign resp_byte = (idx_q == 3'd0) ? status_q : rdata_q[{bsel, 3'b000} +: 8];
   assign last = !(!we_q && status_q == STATUS_OK) || idx_q == 3'd4;
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tmo_d    = tmo_q;
      idx_d    = idx_q;
      status_d = status_q;
      rdata_d  = rdata_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      cyc_d    = cyc_q;
      wr_d     = 1'b0;
      wrd_d    = wrd_q;
      case (state_q)
         S_IDLE: if (fifo_read) begin
            cnt_d = 2'd0;
            idx_d = 3'd0;
            if (fifo_readdata == 8'h01 || fifo_readdata == 8'h02) begin
               we_d    = fifo_readdata == 8'h01;
               state_d = S_ADDR;
            end else begin
               status_d = STATUS_BADCMD;
               state_d  = S_RESP;
            end
         end
         S_ADDR: if (fifo_read) begin
            addr_d = {fifo_readdata, addr_q[31:8]};
            cnt_d  = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               state_d = we_q ? S_WDATA : S_BUS;
               cyc_d   = !we_q;
               tmo_d   = 16'd0;
            end
         end
         S_WDATA: if (fifo_read) begin
            wdata_d = {fifo_readdata, wdata_q[31:8]};
            cnt_d   = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               state_d = S_BUS;
               cyc_d   = 1'b1;
               tmo_d   = 16'd0;
            end
         end
         S_BUS: begin
            // an ack on the expiry cycle wins over the timeout
            if (cyc_q && bus_ack) begin
               rdata_d  = bus_rdata;
               status_d = STATUS_OK;
               cyc_d    = 1'b0;
               idx_d    = 3'd0;
               state_d  = S_RESP;
            end else if (tmo_q == TMO_LAST) begin
               status_d = STATUS_TIMEOUT;
               cyc_d    = 1'b0;
               idx_d    = 3'd0;
               state_d  = S_RESP;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         S_RESP: if (fifo_readyfordata) begin
            wr_d    = 1'b1;
            wrd_d   = resp_byte;
            idx_d   = idx_q + 3'd1;
            state_d = last ? S_IDLE : S_RESP;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 2'd0;
         tmo_q    <= 16'd0;
         idx_q    <= 3'd0;
         status_q <= 8'd0;
         rdata_q  <= 32'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         we_q     <= 1'b0;
         cyc_q    <= 1'b0;
         wr_q     <= 1'b0;
         wrd_q    <= 8'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tmo_q    <= tmo_d;
         idx_q    <= idx_d;
         status_q <= status_d;
         rdata_q  <= rdata_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         cyc_q    <= cyc_d;
         wr_q     <= wr_d;
         wrd_q    <= wrd_d;
      end
   end
endmodule
